// File: rtl/fetch_sequencer.sv
// Fetch-side control sequencer: steps PC/MAR/MDR/IR strobes through the fetch micro-steps,
// hands each instruction to execute, applies branch PC loads and counts retired instructions.
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   run,
  input  logic                   halt_req,
  input  logic                   mem_ready,
  input  logic                   exec_done,
  input  logic                   branch_taken,
  output logic                   PCout,
  output logic                   MARin,
  output logic                   IncPC,
  output logic                   PCin,
  output logic                   Read,
  output logic                   MDRin,
  output logic                   MDRout,
  output logic                   IRin,
  output logic                   exec_start,
  output logic                   busy,
  output logic                   fault,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);
  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_T0       = 3'd1,
    S_T1       = 3'd2,
    S_T2       = 3'd3,
    S_DISPATCH = 3'd4,
    S_WAIT     = 3'd5,
    S_BRANCH   = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t         cur, nxt;
  logic [WCW-1:0] wait_cnt;
  logic           halt_pending;
  logic           stop;

  // A halt only takes effect at an instruction boundary (WAIT or BRANCH exit).
  assign stop  = halt_pending | halt_req | ~run;
  assign state = cur;

  always_ff @(posedge clock) begin
    if (clear) begin
      cur          <= S_IDLE;
      wait_cnt     <= '0;
      halt_pending <= 1'b0;
      instr_count  <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_T0)
        wait_cnt <= '0;
      else if (cur == S_T1 && !mem_ready && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + WCW'(1);
      if (cur == S_IDLE)
        halt_pending <= 1'b0;
      else if (halt_req && cur != S_FAULT)
        halt_pending <= 1'b1;
      if (cur == S_WAIT && exec_done)
        instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    nxt        = cur;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    exec_start = 1'b0;
    busy       = 1'b1;
    fault      = 1'b0;
    case (cur)
      S_IDLE: begin
        busy = 1'b0;
        if (run) nxt = S_T0;
      end
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        nxt   = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // Data arriving on the last allowed cycle beats the timeout.
        if (mem_ready)                  nxt = S_T2;
        else if (wait_cnt == WAIT_LAST) nxt = S_FAULT;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        nxt    = S_DISPATCH;
      end
      S_DISPATCH: begin
        exec_start = 1'b1;
        nxt        = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done) begin
          if (branch_taken) nxt = S_BRANCH;
          else if (stop)    nxt = S_IDLE;
          else              nxt = S_T0;
        end
      end
      S_BRANCH: begin
        PCin = 1'b1;
        nxt  = stop ? S_IDLE : S_T0;
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model plans each instruction's
// phase lengths, queues the expected per-cycle outputs, and a monitor compares every cycle.
module tb_fetch_sequencer;
  localparam int TO = 8;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic clear, run, halt_req, mem_ready, exec_done, branch_taken;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, exec_start, busy, fault;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  fetch_sequencer #(.MEM_TIMEOUT(TO), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .clear(clear), .run(run), .halt_req(halt_req),
    .mem_ready(mem_ready), .exec_done(exec_done), .branch_taken(branch_taken),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .exec_start(exec_start),
    .busy(busy), .fault(fault), .state(state), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mc = 0;       // retired-instruction count of the model
  bit   hp = 1'b0;    // a halt has been requested since leaving IDLE
  bit   quiet = 1'b0; // suppress random halts / run drops

  // Output table per state: {PCout,MARin,IncPC,PCin,Read,MDRin,MDRout,IRin,exec_start,busy,fault}
  function automatic logic [10:0] strobes(input logic [2:0] s);
    case (s)
      3'd0:    return 11'b00000000000;
      3'd1:    return 11'b11100000010;
      3'd2:    return 11'b00001100010;
      3'd3:    return 11'b00000011010;
      3'd4:    return 11'b00000000110;
      3'd5:    return 11'b00000000010;
      3'd6:    return 11'b00010000010;
      default: return 11'b00000000001;
    endcase
  endfunction

  always @(negedge clock) begin
    exp_t        e;
    logic [10:0] act;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, exec_start, busy, fault};
      vectors++;
      if (state !== e.st || act !== strobes(e.st) || instr_count !== e.cnt) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got state=%0d strobes=%b count=%0d, expected state=%0d strobes=%b count=%0d",
                 $time, state, act, instr_count, e.st, strobes(e.st), e.cnt);
      end
    end
  end

  task automatic chk(input string what, input bit ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL t=%0t: %s (state=%0d fault=%b busy=%b count=%0d exec_start=%b)",
               $time, what, state, fault, busy, instr_count, exec_start);
    end
  endtask

  task automatic noise();
    mem_ready    = 1'($urandom_range(0, 1));
    exec_done    = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
    halt_req     = quiet ? 1'b0 : ($urandom_range(0, 39) == 0);
    run          = quiet ? 1'b1 : ($urandom_range(0, 5) != 0);
  endtask

  // Queue the expected outputs for this cycle, then advance one clock.
  task automatic cyc(input logic [2:0] st);
    exp_t e;
    e.st  = st;
    e.cnt = CW'(mc);
    sb_q.push_back(e);
    if (st != 3'd0 && st != 3'd7 && halt_req) hp = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_phase(input int n);
    hp = 1'b0;
    for (int i = 0; i < n; i++) begin
      noise(); run = 1'b0; cyc(3'd0);
    end
    noise(); run = 1'b1; cyc(3'd0);
  endtask

  // One instruction: lat memory wait cycles, elat execute wait cycles.
  task automatic do_instr(input int lat, input int elat, input bit br, input bit hreq_t1);
    noise(); cyc(3'd1);
    for (int i = 0; i < lat && i < TO; i++) begin
      noise(); mem_ready = 1'b0;
      if (hreq_t1 && i == 0) halt_req = 1'b1;
      cyc(3'd2);
    end
    if (lat >= TO) begin
      chk("expired memory wait must enter FAULT with all strobes low",
          state === 3'd7 && fault === 1'b1 && busy === 1'b0 &&
          {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, exec_start} === 9'b0);
      for (int k = 0; k < 3; k++) begin noise(); cyc(3'd7); end
      noise(); clear = 1'b1; cyc(3'd7); clear = 1'b0;
      mc = 0; hp = 1'b0;
      idle_phase($urandom_range(0, 2));
      return;
    end
    noise(); mem_ready = 1'b1;
    if (hreq_t1 && lat == 0) halt_req = 1'b1;
    cyc(3'd2);
    noise(); cyc(3'd3);
    noise(); cyc(3'd4);
    for (int i = 0; i < elat; i++) begin
      noise(); exec_done = 1'b0; cyc(3'd5);
    end
    noise(); exec_done = 1'b1; branch_taken = br; cyc(3'd5);
    mc++;
    if (br) begin noise(); cyc(3'd6); end
    if (hp || !run) idle_phase($urandom_range(0, 2));
  endtask

  task automatic clear_in_wait();
    noise(); cyc(3'd1);
    noise(); mem_ready = 1'b1; cyc(3'd2);
    noise(); cyc(3'd3);
    noise(); cyc(3'd4);
    noise(); exec_done = 1'b0; cyc(3'd5);
    noise(); exec_done = 1'b1; clear = 1'b1; cyc(3'd5); clear = 1'b0;
    chk("clear during WAIT must return to IDLE with count 0",
        state === 3'd0 && instr_count === '0 && exec_start === 1'b0);
    mc = 0; hp = 1'b0;
    idle_phase(1);
  endtask

  initial begin
    clear = 1'b1; quiet = 1'b1;
    noise();
    @(posedge clock);
    #1;
    chk("reset state",
        state === 3'd0 && fault === 1'b0 && instr_count === '0 && exec_start === 1'b0 &&
        {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} === 8'b0);
    cyc(3'd0);
    clear = 1'b0;
    idle_phase(1);

    // Back-to-back zero-wait fetches, memory waits including the last allowed cycle, a branch.
    for (int i = 0; i < 4; i++) do_instr(0, 0, 1'b0, 1'b0);
    do_instr(3, 0, 1'b0, 1'b0);
    do_instr(TO - 1, 1, 1'b0, 1'b0);
    do_instr(0, 0, 1'b1, 1'b0);
    do_instr(1, 2, 1'b0, 1'b1);
    do_instr(TO, 0, 1'b0, 1'b0);
    clear_in_wait();

    quiet = 1'b0;
    for (int n = 0; n < 120; n++) begin
      int lat;
      lat = ($urandom_range(0, 14) == 0) ? TO : int'($urandom_range(0, TO - 1));
      do_instr(lat, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 1'b0);
    end

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
